// File: rtl/m16bit_div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package m16bit_div_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int LATENCY = DEF_WIDTH + 1;
    localparam logic [DEF_WIDTH-1:0] DIV0_QUOT = '1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/m16bit_div_datapath.sv
// Remainder/quotient/divisor registers around one trial subtracter
// with a restore mux; advanced one bit per step strobe.
module m16bit_div_datapath
    import m16bit_div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iLoad,
    input  logic             iDivZero,
    input  logic             iStep,
    input  logic [WIDTH-1:0] iDividend,
    input  logic [WIDTH-1:0] iDivisor,
    output logic [WIDTH-1:0] oQuot,
    output logic [WIDTH-1:0] oRem
);

    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH:0]   r_shift;
    logic [WIDTH+1:0] diff;
    logic             borrow;

    always_comb begin
        r_shift = {r_q, q_q[WIDTH-1]};
        diff    = {1'b0, r_shift} - {2'b00, d_q};
        // R stays below D, so any set bit above WIDTH-1 means T went negative
        borrow  = |diff[WIDTH+1:WIDTH];
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        if (iLoad) begin
            d_d = iDivisor;
            if (iDivZero) begin
                r_d = iDividend;
                q_d = '1;
            end else begin
                r_d = '0;
                q_d = iDividend;
            end
        end else if (iStep) begin
            q_d = {q_q[WIDTH-2:0], ~borrow};
            r_d = borrow ? r_shift[WIDTH-1:0] : diff[WIDTH-1:0];
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_q <= '0;
            q_q <= '0;
            d_q <= '0;
        end else begin
            r_q <= r_d;
            q_q <= q_d;
            d_q <= d_d;
        end
    end

    assign oQuot = q_q;
    assign oRem  = r_q;

endmodule

// File: rtl/m16bit_div_seq.sv
// Multi-cycle unsigned divide unit: start/done handshake, iteration
// counter and control FSM driving the shift/subtract datapath.
module m16bit_div_seq
    import m16bit_div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iStart,
    input  logic [WIDTH-1:0] iDividend,
    input  logic [WIDTH-1:0] iDivisor,
    output logic             oBusy,
    output logic             oDone,
    output logic [WIDTH-1:0] oQuot,
    output logic [WIDTH-1:0] oRem,
    output logic             oDivZero
);

    localparam int CW = $clog2(WIDTH);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            dz_q, dz_d;
    logic            accept;
    logic            dz_in;
    logic            step;
    logic            last;

    assign accept = iStart && (state_q != RUN);
    assign dz_in  = (iDivisor == '0);
    assign step   = (state_q == RUN);
    assign last   = (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dz_d    = dz_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    state_d = dz_in ? DONE : RUN;
                    cnt_d   = '0;
                    dz_d    = dz_in;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (last) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

    m16bit_div_datapath #(
        .WIDTH(WIDTH)
    ) u_dp (
        .iClk      (iClk),
        .iRst      (iRst),
        .iLoad     (accept),
        .iDivZero  (dz_in),
        .iStep     (step),
        .iDividend (iDividend),
        .iDivisor  (iDivisor),
        .oQuot     (oQuot),
        .oRem      (oRem)
    );

    assign oBusy    = busy_q;
    assign oDone    = done_q;
    assign oDivZero = dz_q;

endmodule

// File: tb/tb_m16bit_div_seq.sv
// Directed checks for the sequential divider: latency, results,
// divide-by-zero, ignored starts, reset abort and back-to-back starts.
module tb_m16bit_div_seq;

    logic        iClk = 1'b0;
    logic        iRst;
    logic        iStart;
    logic [15:0] iDividend;
    logic [15:0] iDivisor;
    logic        oBusy;
    logic        oDone;
    logic [15:0] oQuot;
    logic [15:0] oRem;
    logic        oDivZero;

    int n_chk  = 0;
    int n_pass = 0;

    m16bit_div_seq dut (
        .iClk      (iClk),
        .iRst      (iRst),
        .iStart    (iStart),
        .iDividend (iDividend),
        .iDivisor  (iDivisor),
        .oBusy     (oBusy),
        .oDone     (oDone),
        .oQuot     (oQuot),
        .oRem      (oRem),
        .oDivZero  (oDivZero)
    );

    always #5 iClk = ~iClk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                      tag, got, got, exp, exp);
    endtask

    // Watch win cycles (cycle 1 follows the accepting edge); optionally
    // drive a one-edge start pulse after sampling cycle inj.
    task automatic mon(input int win, input int inj,
                       input logic [15:0] idvd, input logic [15:0] idvs,
                       output int dcyc, output int dcnt, output int bcnt,
                       output logic [15:0] dq, output logic [15:0] dr,
                       output logic ddz,
                       output logic [15:0] lq, output logic [15:0] lr);
        dcyc = 0; dcnt = 0; bcnt = 0;
        dq = '0; dr = '0; ddz = 1'b0;
        for (int c = 1; c <= win; c++) begin
            @(negedge iClk);
            if (oBusy) bcnt++;
            if (oDone) begin
                dcnt++;
                if (dcyc == 0) begin
                    dcyc = c; dq = oQuot; dr = oRem; ddz = oDivZero;
                end
            end
            iStart = (c == inj);
            if (c == inj) begin
                iDividend = idvd;
                iDivisor  = idvs;
            end else begin
                iDividend = 16'($urandom);
                iDivisor  = 16'($urandom);
            end
        end
        lq = oQuot;
        lr = oRem;
    endtask

    task automatic op(input string tag, input bit do_start,
                      input logic [15:0] dvd, input logic [15:0] dvs,
                      input logic [15:0] eq, input logic [15:0] er,
                      input logic edz, input int ecyc, input int ebusy,
                      input int win, input int inj,
                      input logic [15:0] idvd, input logic [15:0] idvs);
        int dcyc, dcnt, bcnt;
        logic [15:0] dq, dr, lq, lr;
        logic ddz;
        if (do_start) begin
            @(negedge iClk);
            iStart = 1'b1;
            iDividend = dvd;
            iDivisor = dvs;
        end
        mon(win, inj, idvd, idvs, dcyc, dcnt, bcnt, dq, dr, ddz, lq, lr);
        check({tag, ".done_cyc"}, dcyc, ecyc);
        check({tag, ".done_cnt"}, dcnt, 1);
        check({tag, ".busy_cyc"}, bcnt, ebusy);
        check({tag, ".quot"}, dq, eq);
        check({tag, ".rem"}, dr, er);
        check({tag, ".divzero"}, ddz, edz);
        check({tag, ".held_quot"}, lq, eq);
        check({tag, ".held_rem"}, lr, er);
    endtask

    initial begin
        int dcyc, dcnt, bcnt;
        logic [15:0] dq, dr, lq, lr;
        logic ddz;

        iRst = 1'b1;
        iStart = 1'b0;
        iDividend = '0;
        iDivisor = '0;
        repeat (2) @(negedge iClk);
        check("reset.outs", {oBusy, oDone, oDivZero, oQuot, oRem}, '0);
        iRst = 1'b0;
        @(negedge iClk);

        op("d100_7", 1, 16'd100, 16'd7, 16'd14, 16'd2, 0,
           17, 16, 20, 0, 0, 0);
        op("dffff_1", 1, 16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 0,
           17, 16, 20, 0, 0, 0);
        op("d5_9", 1, 16'd5, 16'd9, 16'd0, 16'd5, 0,
           17, 16, 20, 0, 0, 0);
        op("div0", 1, 16'h1234, 16'd0, 16'hFFFF, 16'h1234, 1,
           1, 0, 20, 0, 0, 0);
        op("dffff_ffff", 1, 16'hFFFF, 16'hFFFF, 16'd1, 16'd0, 0,
           17, 16, 20, 0, 0, 0);
        op("ignore", 1, 16'd1000, 16'd3, 16'd333, 16'd1, 0,
           17, 16, 20, 8, 16'd50, 16'd5);

        // Abort mid-run with an asynchronous reset pulse.
        @(negedge iClk);
        iStart = 1'b1;
        iDividend = 16'd40000;
        iDivisor = 16'd123;
        mon(6, 0, 0, 0, dcyc, dcnt, bcnt, dq, dr, ddz, lq, lr);
        check("abort.busy_pre", bcnt, 6);
        iRst = 1'b1;
        #1;
        check("abort.outs", {oBusy, oDone, oDivZero, oQuot, oRem}, '0);
        @(negedge iClk);
        iRst = 1'b0;
        mon(20, 0, 0, 0, dcyc, dcnt, bcnt, dq, dr, ddz, lq, lr);
        check("abort.no_done", dcnt, 0);
        check("abort.no_busy", bcnt, 0);
        op("d81_9", 1, 16'd81, 16'd9, 16'd9, 16'd0, 0,
           17, 16, 20, 0, 0, 0);

        // Start held through the DONE cycle.
        op("b2b_1", 1, 16'd77, 16'd7, 16'd11, 16'd0, 0,
           17, 16, 17, 17, 16'd200, 16'd6);
        op("b2b_2", 0, 0, 0, 16'd33, 16'd2, 0,
           17, 16, 20, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
